// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps a 2-bit A/B select index at a programmable
// dwell rate, either for one pass or continuously, feeding a 2:4 decoder.
module decoder_scan_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic             A,
  output logic             B,
  output logic             step,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [1:0]       idx;
  logic [DIV_W-1:0] pre, div_q;
  logic             mode_q, dir_q;
  assign A    = idx[1];
  assign B    = idx[0];
  assign busy = state == RUN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      pre    <= '0;
      div_q  <= '0;
      mode_q <= 1'b0;
      dir_q  <= 1'b0;
      step   <= 1'b0;
      done   <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && !stop) begin
          mode_q <= mode;
          dir_q  <= dir;
          div_q  <= div;
          idx    <= dir ? 2'd3 : 2'd0;
          pre    <= '0;
          state  <= RUN;
        end
      end else if (stop) begin
        pre   <= '0;
        state <= IDLE;
      end else if (pre == div_q) begin
        pre <= '0;
        // the last index of a single pass ends the scan instead of stepping
        if (mode_q && idx == (dir_q ? 2'd0 : 2'd3)) begin
          done  <= 1'b1;
          state <= IDLE;
        end else begin
          idx  <= dir_q ? idx - 2'd1 : idx + 2'd1;
          step <= 1'b1;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end
endmodule
